// File: rtl/midi_tx_arbiter.sv
// Two-requester MIDI message arbiter: round-robin grant, serialises status/data
// bytes to a UART with running-status suppression and inter-byte holdoff.
module midi_tx_arbiter #(
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] status0,
  input  logic [7:0] status1,
  input  logic [7:0] d1_0,
  input  logic [7:0] d1_1,
  input  logic [7:0] d2_0,
  input  logic [7:0] d2_1,
  output logic       ack0,
  output logic       ack1,
  input  logic       uart_ready,
  output logic [7:0] midi_byte,
  output logic       midi_send,
  output logic       busy,
  output logic       err
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, SEND_ST, SEND_D1, SEND_D2} state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] st;
    logic [BYTE_W-1:0] d1;
    logic [BYTE_W-1:0] d2;
  } msg_t;

  state_e            state_q, state_d;
  msg_t              msg_q, msg_d;
  logic [BYTE_W-1:0] last_status_q, last_status_d;
  logic              rr_last_q, rr_last_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              send_q, send_d, holdoff_q;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              busy_q, busy_d, err_q, err_d;

  logic              grant_valid, grant1, skip_status, can_send, three_byte;
  msg_t              grant_msg;

  // Grant selection: a lone request always wins, a tie goes to the other side
  assign grant_valid = (state_q == IDLE) && (req0 || req1);
  assign grant1      = req1 && (!req0 || !rr_last_q);
  assign grant_msg   = grant1 ? '{st: status1, d1: d1_1 & 8'h7F, d2: d2_1 & 8'h7F}
                              : '{st: status0, d1: d1_0 & 8'h7F, d2: d2_0 & 8'h7F};
  assign skip_status = RUNNING_STATUS && grant_msg.st[7] && (grant_msg.st == last_status_q);
  assign can_send    = uart_ready && !holdoff_q;
  assign three_byte  = !((msg_q.st[7:4] == 4'hC) || (msg_q.st[7:4] == 4'hD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          if (grant_msg.st[7] && skip_status) state_d = SEND_D1;
          else                                state_d = SEND_ST;
        end
      end
      SEND_ST: begin
        if (!msg_q.st[7])  state_d = IDLE;
        else if (can_send) state_d = SEND_D1;
      end
      SEND_D1: if (can_send) state_d = three_byte ? SEND_D2 : IDLE;
      SEND_D2: if (can_send) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msg_d         = msg_q;
    last_status_d = last_status_q;
    rr_last_d     = rr_last_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    send_d        = 1'b0;
    byte_d        = byte_q;
    err_d         = 1'b0;
    busy_d        = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          msg_d     = grant_msg;
          ack0_d    = !grant1;
          ack1_d    = grant1;
          rr_last_d = grant1;
          if (skip_status) last_status_d = grant_msg.st;
        end
      end
      SEND_ST: begin
        if (!msg_q.st[7]) begin
          err_d = 1'b1;
        end else if (can_send) begin
          send_d        = 1'b1;
          byte_d        = msg_q.st;
          last_status_d = msg_q.st;
        end
      end
      SEND_D1: begin
        if (can_send) begin
          send_d = 1'b1;
          byte_d = msg_q.d1;
        end
      end
      SEND_D2: begin
        if (can_send) begin
          send_d = 1'b1;
          byte_d = msg_q.d2;
        end
      end
      default: ;
    endcase
  end

  // holdoff mirrors the strobe so the cycle after each send is never a send
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q         <= '0;
      last_status_q <= '0;
      rr_last_q     <= 1'b1;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      send_q        <= 1'b0;
      holdoff_q     <= 1'b0;
      byte_q        <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      msg_q         <= msg_d;
      last_status_q <= last_status_d;
      rr_last_q     <= rr_last_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      send_q        <= send_d;
      holdoff_q     <= send_d;
      byte_q        <= byte_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign midi_send = send_q;
  assign midi_byte = byte_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
